// File: rtl/simplerisc_pkg.sv
// simplerisc_pkg: shared SimpleRisc widths and the EX->MR payload layout
package simplerisc_pkg;
    localparam int XLEN   = 32;
    localparam int CTRL_W = 24;
    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   alu;
        logic [XLEN-1:0]   op2;
        logic [XLEN-1:0]   instr;
        logic [CTRL_W-1:0] ctrl;
    } ex_mr_payload_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones, synchronous clear has priority
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clr_i ? '0 : (inc_i && !(&cnt_q)) ? cnt_q + W'(1) : cnt_q;
    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    assign cnt_o = cnt_q;
endmodule

// File: rtl/ex_mr_skid_stage.sv
// ex_mr_skid_stage: EX->MR valid/ready register with main+skid entries, flush,
// one-cycle branch redirect pulse and a saturating back-pressure counter
module ex_mr_skid_stage #(
    parameter int XLEN   = simplerisc_pkg::XLEN,
    parameter int CTRL_W = simplerisc_pkg::CTRL_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_alu,
    input  logic [XLEN-1:0]   in_op2,
    input  logic [XLEN-1:0]   in_instr,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              in_br_taken,
    input  logic [XLEN-1:0]   in_br_target,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_alu,
    output logic [XLEN-1:0]   out_op2,
    output logic [XLEN-1:0]   out_instr,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              redirect_valid,
    output logic [XLEN-1:0]   redirect_pc,
    input  logic              perf_clr,
    output logic [CNT_W-1:0]  stall_cnt
);
    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   alu;
        logic [XLEN-1:0]   op2;
        logic [XLEN-1:0]   instr;
        logic [CTRL_W-1:0] ctrl;
    } payload_t;

    payload_t        in_pl, main_q, main_d, skid_q, skid_d;
    logic            main_v_q, main_v_d, skid_v_q, skid_v_d;
    logic            redir_v_q, redir_v_d;
    logic [XLEN-1:0] redir_pc_q, redir_pc_d;
    logic            accept, fire, ld_skid_main, ld_in_main, ld_skid;

    assign in_pl        = '{in_pc, in_alu, in_op2, in_instr, in_ctrl};
    assign in_ready     = !skid_v_q;
    assign accept       = in_valid && !skid_v_q;
    assign fire         = main_v_q && out_ready;
    assign ld_skid_main = fire && skid_v_q;
    assign ld_in_main   = accept && (fire || !main_v_q);
    assign ld_skid      = accept && main_v_q && !fire;

    // payload stays stale on flush; only the valid bits are cleared
    always_comb begin
        main_v_d   = flush ? 1'b0 : (ld_skid_main || ld_in_main) ? 1'b1 : fire ? 1'b0 : main_v_q;
        skid_v_d   = flush ? 1'b0 : ld_skid_main ? 1'b0 : ld_skid ? 1'b1 : skid_v_q;
        main_d     = (!flush && ld_skid_main) ? skid_q : (!flush && ld_in_main) ? in_pl : main_q;
        skid_d     = (!flush && ld_skid) ? in_pl : skid_q;
        redir_v_d  = accept && in_br_taken && !flush;
        redir_pc_d = redir_v_d ? in_br_target : redir_pc_q;
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            main_v_q   <= 1'b0;
            skid_v_q   <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
            redir_v_q  <= 1'b0;
            redir_pc_q <= '0;
        end else begin
            main_v_q   <= main_v_d;
            skid_v_q   <= skid_v_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            redir_v_q  <= redir_v_d;
            redir_pc_q <= redir_pc_d;
        end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (main_v_q && !out_ready),
        .clr_i (perf_clr),
        .cnt_o (stall_cnt)
    );

    assign out_valid      = main_v_q;
    assign out_pc         = main_q.pc;
    assign out_alu        = main_q.alu;
    assign out_op2        = main_q.op2;
    assign out_instr      = main_q.instr;
    assign out_ctrl       = main_q.ctrl;
    assign redirect_valid = redir_v_q;
    assign redirect_pc    = redir_pc_q;
endmodule

// File: tb/tb_ex_mr_skid_stage.sv
// tb_ex_mr_skid_stage: directed stimulus with a queue scoreboard checked on every MR handshake
module tb_ex_mr_skid_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_br_taken, flush, out_valid, out_ready;
    logic [31:0] in_pc, in_alu, in_op2, in_instr, in_br_target;
    logic [23:0] in_ctrl;
    logic [31:0] out_pc, out_alu, out_op2, out_instr, redirect_pc;
    logic [23:0] out_ctrl;
    logic        redirect_valid, perf_clr;
    logic [3:0]  stall_cnt;
    logic [31:0] exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    ex_mr_skid_stage #(.XLEN(32), .CTRL_W(24), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_alu(in_alu), .in_op2(in_op2), .in_instr(in_instr), .in_ctrl(in_ctrl),
        .in_br_taken(in_br_taken), .in_br_target(in_br_target), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_alu(out_alu), .out_op2(out_op2), .out_instr(out_instr), .out_ctrl(out_ctrl),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .perf_clr(perf_clr), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_of(input logic [31:0] pc);   return pc ^ 32'hA5A5_0000; endfunction
    function automatic logic [31:0] op2_of(input logic [31:0] pc);   return ~pc; endfunction
    function automatic logic [31:0] instr_of(input logic [31:0] pc); return {pc[15:0], 16'h0013}; endfunction
    function automatic logic [23:0] ctrl_of(input logic [31:0] pc);  return pc[23:0] ^ 24'h5A5A5A; endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic offer(input logic v, input logic [31:0] pc, input logic expect_out);
        in_valid = v;
        in_pc    = pc;
        in_alu   = alu_of(pc);
        in_op2   = op2_of(pc);
        in_instr = instr_of(pc);
        in_ctrl  = ctrl_of(pc);
        if (expect_out) exp_q.push_back(pc);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // monitor: every handshake pops the oldest expected beat
    always @(negedge clk)
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_unexpected: got pc %h expected no beat", out_pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("sb_pc", out_pc, e);
                chk("sb_alu", out_alu, alu_of(e));
                chk("sb_op2", out_op2, op2_of(e));
                chk("sb_instr", out_instr, instr_of(e));
                chk("sb_ctrl", {8'h0, out_ctrl}, {8'h0, ctrl_of(e)});
            end
        end

    initial begin
        rst = 1'b0;
        flush = 1'b0; out_ready = 1'b0; perf_clr = 1'b0;
        in_br_taken = 1'b0; in_br_target = '0;
        offer(1'b0, 32'h0, 1'b0);
        #3;
        chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'h0, in_ready}, 32'd1);
        chk("rst_stall_cnt", {28'h0, stall_cnt}, 32'd0);
        chk("rst_redirect", {31'h0, redirect_valid}, 32'd0);
        chk("rst_out_pc", out_pc, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        tick;
        chk("post_rst_in_ready", {31'h0, in_ready}, 32'd1);

        // streaming flow, one beat per cycle
        out_ready = 1'b1;
        foreach (exp_q[i]) ;
        for (int i = 0; i < 3; i++) begin
            offer(1'b1, 32'h10 + 32'(4 * i), 1'b1);
            tick;
            chk("flow_out_valid", {31'h0, out_valid}, 32'd1);
            chk("flow_out_pc", out_pc, 32'h10 + 32'(4 * i));
            chk("flow_in_ready", {31'h0, in_ready}, 32'd1);
        end
        offer(1'b0, 32'h0, 1'b0);
        tick;
        chk("flow_drain", {31'h0, out_valid}, 32'd0);

        // back-pressure into the skid entry
        perf_clr = 1'b1; tick; perf_clr = 1'b0;
        out_ready = 1'b0;
        offer(1'b1, 32'h20, 1'b1); tick;
        chk("bp_in_ready1", {31'h0, in_ready}, 32'd1);
        offer(1'b1, 32'h24, 1'b1); tick;
        chk("bp_in_ready2", {31'h0, in_ready}, 32'd0);
        chk("bp_stall1", {28'h0, stall_cnt}, 32'd1);
        offer(1'b1, 32'h28, 1'b1); tick;
        chk("bp_hold_pc", out_pc, 32'h20);
        tick;
        chk("bp_stall3", {28'h0, stall_cnt}, 32'd3);
        out_ready = 1'b1; tick;
        chk("bp_skid_to_main", out_pc, 32'h24);
        chk("bp_ready_back", {31'h0, in_ready}, 32'd1);
        tick;
        chk("bp_third", out_pc, 32'h28);
        offer(1'b0, 32'h0, 1'b0); tick;
        chk("bp_empty", {31'h0, out_valid}, 32'd0);
        chk("bp_stall_final", {28'h0, stall_cnt}, 32'd3);

        // flush with both entries full, then flush killing a just-accepted beat
        out_ready = 1'b0;
        offer(1'b1, 32'h30, 1'b0); tick;
        offer(1'b1, 32'h34, 1'b0); tick;
        chk("fl_full", {31'h0, in_ready}, 32'd0);
        offer(1'b1, 32'h38, 1'b0); flush = 1'b1; tick;
        chk("fl_out_valid", {31'h0, out_valid}, 32'd0);
        chk("fl_in_ready", {31'h0, in_ready}, 32'd1);
        offer(1'b1, 32'h3C, 1'b0); tick;
        flush = 1'b0; offer(1'b0, 32'h0, 1'b0); out_ready = 1'b1; tick;
        chk("fl_dropped", {31'h0, out_valid}, 32'd0);

        // redirect pulse while the beat stays stalled
        out_ready = 1'b0;
        offer(1'b1, 32'h40, 1'b1); in_br_taken = 1'b1; in_br_target = 32'h100; tick;
        chk("rd_pulse", {31'h0, redirect_valid}, 32'd1);
        chk("rd_pc", redirect_pc, 32'h100);
        offer(1'b0, 32'h0, 1'b0); in_br_taken = 1'b0; in_br_target = 32'h0; tick;
        chk("rd_single", {31'h0, redirect_valid}, 32'd0);
        chk("rd_pc_hold", redirect_pc, 32'h100);
        chk("rd_stalled", {31'h0, out_valid}, 32'd1);
        out_ready = 1'b1; tick;
        chk("rd_drain", {31'h0, out_valid}, 32'd0);

        // stall counter saturation and clear
        perf_clr = 1'b1; tick; perf_clr = 1'b0;
        out_ready = 1'b0;
        offer(1'b1, 32'h50, 1'b1); tick;
        offer(1'b0, 32'h0, 1'b0);
        repeat (20) tick;
        chk("sat_15", {28'h0, stall_cnt}, 32'd15);
        perf_clr = 1'b1; tick; perf_clr = 1'b0;
        chk("sat_clr", {28'h0, stall_cnt}, 32'd0);
        tick;
        chk("sat_restart", {28'h0, stall_cnt}, 32'd1);
        out_ready = 1'b1; tick;
        chk("sat_drain", {31'h0, out_valid}, 32'd0);

        // asynchronous reset between edges with both entries full
        out_ready = 1'b0;
        offer(1'b1, 32'h60, 1'b0); in_br_taken = 1'b1; in_br_target = 32'h200; tick;
        in_br_taken = 1'b0;
        offer(1'b1, 32'h64, 1'b0); tick;
        offer(1'b0, 32'h0, 1'b0);
        chk("ar_full", {31'h0, in_ready}, 32'd0);
        #2 rst = 1'b0;
        #1;
        chk("ar_out_valid", {31'h0, out_valid}, 32'd0);
        chk("ar_in_ready", {31'h0, in_ready}, 32'd1);
        chk("ar_stall", {28'h0, stall_cnt}, 32'd0);
        chk("ar_redirect_pc", redirect_pc, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        tick;
        chk("sb_leftover", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
